// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  // One prefetched word together with the address it was read from.
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  // Clear the byte-offset bits of an address.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/bus_if.sv
// Word-wide read port with one cycle of read latency.
interface bus_if;
  import instr_fetch_pkg::*;

  logic [ADDR_W-1:0] raddr;
  logic              ren;
  logic [DATA_W-1:0] rdata;

  modport master (output raddr, output ren, input rdata);
  modport slave  (input raddr, input ren, output rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries; flush overrides push and pop.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 wdata,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head_c,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok, mem_we;

  // Pointer advance with wrap for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next-state for pointers and occupancy.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);
    mem_we   = push_ok && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed when count is non-zero.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wdata;
  end

  assign head_c = mem_q[rd_ptr_q];
  assign count  = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Sequential instruction prefetcher with redirect/flush feeding a valid/ready decode port.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_if.master             bus,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic              stale_q, stale_d;
  logic [CNT_W-1:0]  count;
  fetch_entry_t      head_c, push_entry;
  logic              ren_c, push_c, pop_c;

  // Issue only with credit for both buffered and in-flight words; pops never add credit.
  always_comb begin
    ren_c            = rst_n && !redirect &&
                       ((SUM_W'(count) + SUM_W'(inflight_q)) < SUM_W'(DEPTH));
    push_c           = inflight_q && !stale_q && !redirect;
    pop_c            = out_valid && out_ready && !redirect;
    push_entry.pc    = req_pc_q;
    push_entry.instr = bus.rdata;
  end

  // Fetch address, request tracking and stale-response marking.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = ren_c;
    stale_d    = redirect && inflight_q;
    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (ren_c) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(WORD_BYTES);
      req_pc_d   = fetch_pc_q;
    end
  end

  // Fetch state registers; reset abandons any outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= word_align(RESET_PC);
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push_c),
    .wdata  (push_entry),
    .pop    (pop_c),
    .flush  (redirect),
    .head_c (head_c),
    .count  (count)
  );

  // Bus drive and decode-side presentation; payload reads zero when nothing is valid.
  always_comb begin
    bus.raddr = word_align(fetch_pc_q);
    bus.ren   = ren_c;
    out_valid = (count != '0);
    out_instr = out_valid ? head_c.instr : '0;
    out_pc    = out_valid ? head_c.pc    : '0;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table plus multi-cycle corner sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_tests = 0;
  int n_fail  = 0;

  bus_if bus_i ();

  instr_fetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_i),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc)
  );

  always #5 clk = ~clk;

  // ROM image: word i holds i*16, i.e. data = addr << 2.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {a[29:0], 2'b00};
  endfunction

  always @(posedge clk) begin
    if (bus_i.ren) bus_i.rdata <= rom_word(bus_i.raddr);
  end

  typedef struct {
    logic        redirect;
    logic [31:0] rpc;
    logic        ready;
    logic        ren;
    logic [31:0] raddr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge and let combinational outputs settle.
  task automatic drive(input logic r, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    redirect    = r;
    redirect_pc = rpc;
    out_ready   = rdy;
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    out_ready   = 1'b1;
    #1;
    check("rst_ren",   32'(bus_i.ren), 32'd0);
    check("rst_raddr", bus_i.raddr,    32'h0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc",    out_pc,         32'h0);
    check("rst_instr", out_instr,      32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic r, input logic [31:0] rpc, input logic rdy,
                              input logic ren, input logic [31:0] ra, input logic v,
                              input logic [31:0] pc, input logic [31:0] ins);
    vec_t t;
    t.redirect = r;  t.rpc   = rpc; t.ready = rdy;
    t.ren      = ren; t.raddr = ra; t.valid = v;
    t.pc       = pc;  t.instr = ins;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_ren;
    int          n_pop;
    int          lat;
    logic        got_ra;
    logic [31:0] first_ra;
    logic [31:0] first_pc;

    // Streaming, redirect to unaligned 0x103, then redirect to top of address space.
    vecs[0]  = mk(0, 32'h0,         1, 1, 32'h000,       0, 32'h000,       32'h000);
    vecs[1]  = mk(0, 32'h0,         1, 1, 32'h004,       0, 32'h000,       32'h000);
    vecs[2]  = mk(0, 32'h0,         1, 1, 32'h008,       1, 32'h000,       32'h000);
    vecs[3]  = mk(0, 32'h0,         1, 1, 32'h00C,       1, 32'h004,       32'h010);
    vecs[4]  = mk(0, 32'h0,         1, 1, 32'h010,       1, 32'h008,       32'h020);
    vecs[5]  = mk(1, 32'h103,       1, 0, 32'h014,       1, 32'h00C,       32'h030);
    vecs[6]  = mk(0, 32'h0,         1, 1, 32'h100,       0, 32'h000,       32'h000);
    vecs[7]  = mk(0, 32'h0,         1, 1, 32'h104,       0, 32'h000,       32'h000);
    vecs[8]  = mk(0, 32'h0,         1, 1, 32'h108,       1, 32'h100,       32'h400);
    vecs[9]  = mk(0, 32'h0,         1, 1, 32'h10C,       1, 32'h104,       32'h410);
    vecs[10] = mk(1, 32'hFFFF_FFFC, 1, 0, 32'h110,       1, 32'h108,       32'h420);
    vecs[11] = mk(0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h000,       32'h000);
    vecs[12] = mk(0, 32'h0,         1, 1, 32'h000,       0, 32'h000,       32'h000);
    vecs[13] = mk(0, 32'h0,         1, 1, 32'h004,       1, 32'hFFFF_FFFC, 32'hFFFF_FFF0);
    vecs[14] = mk(0, 32'h0,         1, 1, 32'h008,       1, 32'h000,       32'h000);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].redirect, vecs[i].rpc, vecs[i].ready);
      check($sformatf("row%0d_ren", i),   32'(bus_i.ren), 32'(vecs[i].ren));
      check($sformatf("row%0d_raddr", i), bus_i.raddr,    vecs[i].raddr);
      check($sformatf("row%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      check($sformatf("row%0d_pc", i),    out_pc,         vecs[i].pc);
      check($sformatf("row%0d_instr", i), out_instr,      vecs[i].instr);
    end

    // Backpressure: exactly DEPTH reads, head held, ordered drain, resume at 0x10.
    do_reset();
    n_ren = 0;
    for (int k = 0; k < 10; k++) begin
      drive(0, 32'h0, 0);
      if (bus_i.ren) n_ren++;
      if (out_valid) check("bp_hold_pc", out_pc, 32'h0);
    end
    check("bp_reads_issued", 32'(n_ren), 32'd4);
    check("bp_ren_idle", 32'(bus_i.ren), 32'd0);
    n_pop  = 0;
    got_ra = 1'b0;
    first_ra = 32'hDEAD_BEEF;
    for (int k = 0; k < 20 && n_pop < 5; k++) begin
      drive(0, 32'h0, 1);
      if (bus_i.ren && !got_ra) begin
        got_ra   = 1'b1;
        first_ra = bus_i.raddr;
      end
      if (out_valid) begin
        check($sformatf("bp_pop%0d_pc", n_pop),    out_pc,    32'(n_pop * 4));
        check($sformatf("bp_pop%0d_instr", n_pop), out_instr, 32'(n_pop * 16));
        n_pop++;
      end
    end
    check("bp_pops", 32'(n_pop), 32'd5);
    check("bp_resume_raddr", first_ra, 32'h10);

    // Redirect while 0x20 is in flight and two entries are buffered.
    do_reset();
    for (int k = 0; k < 8; k++) drive(0, 32'h0, 1);
    drive(0, 32'h0, 0);
    check("rd_issue_0x20", bus_i.raddr, 32'h20);
    drive(1, 32'h100, 1);
    check("rd_head_before", out_pc, 32'h18);
    check("rd_ren_blocked", 32'(bus_i.ren), 32'd0);
    lat      = -1;
    first_pc = 32'hDEAD_BEEF;
    for (int k = 0; k < 8 && lat < 0; k++) begin
      drive(0, 32'h0, 1);
      if (k == 0) begin
        check("rd_flushed", 32'(out_valid), 32'd0);
        check("rd_new_raddr", bus_i.raddr, 32'h100);
      end
      if (out_valid) begin
        lat      = k + 1;
        first_pc = out_pc;
      end
    end
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_first_pc", first_pc, 32'h100);

    // Asynchronous reset with a read outstanding.
    do_reset();
    for (int k = 0; k < 5; k++) drive(0, 32'h0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_ren_drop", 32'(bus_i.ren), 32'd0);
    check("ar_valid_drop", 32'(out_valid), 32'd0);
    do_reset();
    drive(0, 32'h0, 1);
    check("ar_restart_raddr", bus_i.raddr, 32'h0);
    drive(0, 32'h0, 1);
    check("ar_no_stale", 32'(out_valid), 32'd0);
    drive(0, 32'h0, 1);
    check("ar_first_pc", out_pc, 32'h0);
    check("ar_first_valid", 32'(out_valid), 32'd1);
    drive(0, 32'h0, 1);
    check("ar_second_pc", out_pc, 32'h4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
